// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared definitions for the note sequencer: FSM state
//               encoding, song record field positions, END control code and
//               default ROM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    // Default song ROM geometry: 64 records of 12 bits
    localparam int c_ADDR_W_DEF = 6;
    localparam int c_REC_W_DEF  = 12;

    // Song record layout: [11:6] pitch, [5:3] length (beats-1), [2:0] ctrl
    localparam int c_PITCH_HI = 11;
    localparam int c_PITCH_LO = 6;
    localparam int c_LEN_HI   = 5;
    localparam int c_LEN_LO   = 3;
    localparam int c_CTRL_HI  = 2;
    localparam int c_CTRL_LO  = 0;

    // Control code marking the end of the song; every other code is a note
    localparam logic [2:0] c_CTRL_END = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_end_rec(input logic [2:0] ctrl);
        return (ctrl == c_CTRL_END);
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer_if
// Description : Control/status bundle of the note sequencer, plus the write
//               port used to load the song image into the song ROM.
// Revision    : 1.0 - initial release
// ============================================================================
interface note_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int REC_W  = 12
) ();
    // Playback control
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [1:0]        tempo_sel;
    logic              play_next;

    // Song image load port
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [REC_W-1:0]  rom_wdata;

    // Playback status
    logic [ADDR_W-1:0] rom_addr;
    logic [5:0]        note_pitch;
    logic [2:0]        note_length;
    logic [1:0]        tempo;
    logic              note_valid;
    logic              playing;
    logic              song_done;

    modport master (
        output start, stop, loop_en, tempo_sel, play_next,
        output rom_we, rom_waddr, rom_wdata,
        input  rom_addr, note_pitch, note_length, tempo,
        input  note_valid, playing, song_done
    );

    modport slave (
        input  start, stop, loop_en, tempo_sel, play_next,
        input  rom_we, rom_waddr, rom_wdata,
        output rom_addr, note_pitch, note_length, tempo,
        output note_valid, playing, song_done
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer_fsm.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer_fsm
// Description : Playback controller. Walks the song ROM one record per note,
//               presents pitch/length/tempo to the synth, handles looping,
//               end-of-song and abort. Holds no memory of its own.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer_fsm
    import synth_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int REC_W  = c_REC_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    input  logic              play_next,
    input  logic [REC_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [5:0]        note_pitch,
    output logic [2:0]        note_length,
    output logic [1:0]        tempo,
    output logic              note_valid,
    output logic              playing,
    output logic              song_done
);
    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [5:0]        pitch_q;
    logic [2:0]        length_q;
    logic [1:0]        tempo_q;
    logic              valid_q;
    logic              playing_q;
    logic              done_q;

    // Record fields of the word returned for the previous cycle's address
    logic [5:0] rec_pitch_d;
    logic [2:0] rec_len_d;
    logic [2:0] rec_ctrl_d;

    assign rec_pitch_d = rom_data[c_PITCH_HI:c_PITCH_LO];
    assign rec_len_d   = rom_data[c_LEN_HI:c_LEN_LO];
    assign rec_ctrl_d  = rom_data[c_CTRL_HI:c_CTRL_LO];

    // Playback FSM; every output is a register updated alongside the state
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            pitch_q    <= '0;
            length_q   <= '0;
            tempo_q    <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else if (stop) begin
            // Abort wins over start and play_next
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rom_addr_q <= '0;
                        tempo_q    <= tempo_sel;
                        playing_q  <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // ROM latency cycle; the addressed record arrives next
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (is_end_rec(rec_ctrl_d)) begin
                        valid_q <= 1'b0;
                        if (loop_en) begin
                            rom_addr_q <= '0;
                            state_q    <= ST_FETCH;
                        end else begin
                            // song_done rises together with entry into DONE
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        pitch_q  <= rec_pitch_d;
                        length_q <= rec_len_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play_next) begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                        state_q    <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done_q    <= 1'b0;
                    playing_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    valid_q   <= 1'b0;
                    playing_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr    = rom_addr_q;
    assign note_pitch  = pitch_q;
    assign note_length = length_q;
    assign tempo       = tempo_q;
    assign note_valid  = valid_q;
    assign playing     = playing_q;
    assign song_done   = done_q;

endmodule
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
// Module      : song_rom
// Description : Song record store, REC_W x 2^ADDR_W, with a registered
//               (one-cycle latency) read port and a write port used only to
//               load the song image.
// Revision    : 1.0 - initial release
// ============================================================================
module song_rom #(
    parameter int ADDR_W = 6,
    parameter int REC_W  = 12
) (
    input  logic              CLOCK_50,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [REC_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [REC_W-1:0]  rdata_o
);
    logic [REC_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [REC_W-1:0] rdata_q;

    // Image load and synchronous read; data appears the cycle after the address
    always_ff @(posedge CLOCK_50) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Top level: playback FSM beside its song ROM, exposed through
//               the note_sequencer_if bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import synth_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int REC_W  = c_REC_W_DEF
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    note_sequencer_if.slave bus
);
    logic [ADDR_W-1:0] rom_addr;
    logic [REC_W-1:0]  rom_data;

    song_rom #(
        .ADDR_W (ADDR_W),
        .REC_W  (REC_W)
    ) u_song_rom (
        .CLOCK_50 (CLOCK_50),
        .we_i     (bus.rom_we),
        .waddr_i  (bus.rom_waddr),
        .wdata_i  (bus.rom_wdata),
        .raddr_i  (rom_addr),
        .rdata_o  (rom_data)
    );

    note_sequencer_fsm #(
        .ADDR_W (ADDR_W),
        .REC_W  (REC_W)
    ) u_fsm (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start       (bus.start),
        .stop        (bus.stop),
        .loop_en     (bus.loop_en),
        .tempo_sel   (bus.tempo_sel),
        .play_next   (bus.play_next),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .note_pitch  (bus.note_pitch),
        .note_length (bus.note_length),
        .tempo       (bus.tempo),
        .note_valid  (bus.note_valid),
        .playing     (bus.playing),
        .song_done   (bus.song_done)
    );

    assign bus.rom_addr = rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_sequencer
// Description : Self-checking bench for note_sequencer. A song-level model
//               (ROM image array, note index, fixed two-cycle cost per ROM
//               read) predicts what each note step must present.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] rom_m [64];

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(6), .REC_W(12)) bus ();

    note_sequencer #(.ADDR_W(6), .REC_W(12)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mk_rec(input int p, input int l, input int c);
        return {6'(p), 3'(l), 3'(c)};
    endfunction

    task automatic write_rom(input int a, input logic [11:0] r);
        bus.rom_we    = 1'b1;
        bus.rom_waddr = 6'(a);
        bus.rom_wdata = r;
        rom_m[a]      = r;
        tick();
        bus.rom_we    = 1'b0;
    endtask

    // Start a song and step through it note by note against the model
    task automatic run_song(input int max_ev, input bit lp, input bit noise);
        int          idx;
        int          n;
        bit          fin;
        logic [11:0] r;
        logic [1:0]  tsel;
        logic [31:0] got, exp;
        idx  = 0;
        fin  = 1'b0;
        tsel = 2'($urandom);
        bus.tempo_sel = tsel;
        bus.loop_en   = lp;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 32'({bus.playing, bus.rom_addr, bus.song_done, bus.tempo});
        exp = 32'({1'b1, 6'd0, 1'b0, tsel});
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL song_start: got %h want %h", got, exp);
        end
        for (int e = 0; e < max_ev && !fin; e++) begin
            // One ROM read = fetch cycle + load cycle; stray pulses are dropped
            for (int c = 0; c < 2; c++) begin
                bus.play_next = noise ? 1'($urandom) : 1'b0;
                bus.start     = noise ? 1'($urandom) : 1'b0;
                if (noise) bus.tempo_sel = 2'($urandom);
                tick();
            end
            bus.play_next = 1'b0;
            bus.start     = 1'b0;
            r = rom_m[idx];
            if (r[2:0] == 3'b111) begin
                if (lp) begin
                    got = 32'({bus.note_valid, bus.rom_addr, bus.song_done, bus.playing});
                    exp = 32'({1'b0, 6'd0, 1'b0, 1'b1});
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL loop_end at %0d: got %h want %h", idx, got, exp);
                    end
                    idx = 0;
                end else begin
                    got = 32'({bus.song_done, bus.note_valid, bus.playing});
                    exp = 32'b101;
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL end_done at %0d: got %h want %h", idx, got, exp);
                    end
                    tick();
                    got = 32'({bus.song_done, bus.note_valid, bus.playing});
                    exp = 32'b000;
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL end_idle: got %h want %h", got, exp);
                    end
                    fin = 1'b1;
                end
            end else begin
                got = 32'({bus.note_valid, bus.note_pitch, bus.note_length, bus.rom_addr,
                           bus.tempo, bus.song_done});
                exp = 32'({1'b1, r[11:6], r[5:3], 6'(idx), tsel, 1'b0});
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL note_load at %0d: got %h want %h", idx, got, exp);
                end
                n = noise ? int'($urandom_range(0, 2)) : 0;
                repeat (n) begin
                    bus.start     = 1'($urandom);
                    bus.tempo_sel = 2'($urandom);
                    tick();
                    got = 32'({bus.rom_addr, bus.note_valid, bus.note_pitch, bus.tempo});
                    exp = 32'({6'(idx), 1'b1, r[11:6], tsel});
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL note_hold at %0d: got %h want %h", idx, got, exp);
                    end
                end
                bus.start     = 1'b0;
                bus.play_next = 1'b1;
                tick();
                bus.play_next = 1'b0;
                idx = (idx + 1) % 64;
                got = 32'({bus.rom_addr, bus.note_valid, bus.note_pitch, bus.playing});
                exp = 32'({6'(idx), 1'b1, r[11:6], 1'b1});
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL advance to %0d: got %h want %h", idx, got, exp);
                end
            end
        end
        if (!fin) begin
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            got = 32'({bus.playing, bus.note_valid, bus.rom_addr, bus.song_done});
            exp = 32'd0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL song_stop: got %h want %h", got, exp);
            end
        end
        bus.tempo_sel = 2'd0;
        bus.loop_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        got = 32'({bus.rom_addr, bus.note_pitch, bus.note_length, bus.tempo,
                   bus.note_valid, bus.playing, bus.song_done});
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", got);
        end
    endtask

    task automatic test_basic_note();
        logic [31:0] got, exp;
        write_rom(0, mk_rec(12, 3, 0));
        write_rom(1, mk_rec(5, 1, 2));
        bus.tempo_sel = 2'd2;
        bus.start     = 1'b1;
        tick();                               // cycle 0 sampled
        bus.start     = 1'b0;
        bus.tempo_sel = 2'd1;
        got = 32'({bus.playing, bus.rom_addr, bus.note_valid, bus.tempo});
        exp = 32'({1'b1, 6'd0, 1'b0, 2'd2});
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_c0: got %h want %h", got, exp);
        end
        tick();
        checks++;
        if (bus.note_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_c1 valid: got %b want 0", bus.note_valid);
        end
        tick();
        got = 32'({bus.note_pitch, bus.note_length, bus.note_valid});
        exp = 32'({6'd12, 3'd3, 1'b1});
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_c2: got %h want %h", got, exp);
        end
        repeat (4) tick();
        got = 32'({bus.rom_addr, bus.note_valid, bus.note_pitch, bus.tempo});
        exp = 32'({6'd0, 1'b1, 6'd12, 2'd2});
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_hold: got %h want %h", got, exp);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.tempo_sel = 2'd0;
    endtask

    task automatic test_end_no_loop();
        write_rom(0, mk_rec(20, 1, 0));
        write_rom(1, mk_rec(0, 4, 3));
        write_rom(2, mk_rec(9, 2, 7));
        run_song(10, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            checks++;
            if ({bus.song_done, bus.playing} !== 2'b00) begin
                errors++;
                $display("FAIL after_done: got %b want 00", {bus.song_done, bus.playing});
            end
        end
    endtask

    task automatic test_loop();
        run_song(8, 1'b1, 1'b0);
    endtask

    task automatic test_stop_race();
        logic [31:0] got;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();                               // PLAY note 0
        bus.play_next = 1'b1;
        tick();
        bus.play_next = 1'b0;
        tick();
        tick();                               // PLAY note 1, rom_addr 1
        bus.stop      = 1'b1;
        bus.play_next = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.stop      = 1'b0;
        bus.play_next = 1'b0;
        bus.start     = 1'b0;
        got = 32'({bus.playing, bus.rom_addr, bus.note_valid, bus.song_done});
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL stop_race: got %h want 0", got);
        end
        tick();
        tick();
        got = 32'({bus.playing, bus.rom_addr, bus.note_valid});
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL stop_no_fetch: got %h want 0", got);
        end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 64; a++) begin
            write_rom(a, mk_rec(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 6))));
        end
        run_song(68, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] got;
        write_rom(0, mk_rec(33, 5, 1));
        // Reset while in LOAD
        bus.tempo_sel = 2'd3;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();                               // now in LOAD
        resetn = 1'b0;
        tick();
        got = 32'({bus.rom_addr, bus.note_pitch, bus.note_length, bus.tempo,
                   bus.note_valid, bus.playing, bus.song_done});
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_load: got %h want 0", got);
        end
        resetn = 1'b1;
        // Reset while a note is playing
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        got = 32'({bus.rom_addr, bus.note_pitch, bus.note_length, bus.tempo,
                   bus.note_valid, bus.playing, bus.song_done});
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_play: got %h want 0", got);
        end
        resetn = 1'b1;
        bus.tempo_sel = 2'd0;
        repeat (3) begin
            tick();
            checks++;
            if ({bus.song_done, bus.playing} !== 2'b00) begin
                errors++;
                $display("FAIL reset_quiet: got %b want 00", {bus.song_done, bus.playing});
            end
        end
    endtask

    task automatic test_random_songs();
        int len;
        bit lp;
        repeat (6) begin
            len = int'($urandom_range(1, 10));
            lp  = 1'($urandom);
            for (int a = 0; a < len; a++) begin
                write_rom(a, mk_rec(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                                    int'($urandom_range(0, 6))));
            end
            write_rom(len, mk_rec(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 7));
            run_song(lp ? 2 * len + 4 : len + 1, lp, 1'b1);
            tick();
        end
    endtask

    initial begin
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.loop_en   = 1'b0;
        bus.tempo_sel = 2'd0;
        bus.play_next = 1'b0;
        bus.rom_we    = 1'b0;
        bus.rom_waddr = 6'd0;
        bus.rom_wdata = 12'd0;
        for (int a = 0; a < 64; a++) rom_m[a] = 12'd0;

        test_reset();
        test_basic_note();
        test_end_no_loop();
        test_loop();
        test_stop_race();
        test_wrap();
        test_reset_mid_fetch();
        test_random_songs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning song ROM address width (64 note records).
REQ-002 SHALL have parameter REC_W, default 12, meaning song record width.
REQ-003 SHALL have ports `CLOCK_50` in 1 (sole clock, rising edge) and `resetn` in 1 (synchronous, active-low reset).
REQ-004 SHALL have input ports:
- `start` 1: begin playback from address 0.
- `stop` 1: abort playback.
- `loop_en` 1: restart at the end-of-song marker instead of finishing.
- `tempo_sel` 2: tempo code, latched at start.
- `play_next` 1: single-cycle beat-timer pulse meaning the current note has expired.
- `rom_data` REC_W: record at the previously presented address.
REQ-005 SHALL have output ports:
- `rom_addr` ADDR_W: song ROM address.
- `note_pitch` 6: pitch index; 0 means rest.
- `note_length` 3: beats minus 1, fed to the beat timer.
- `tempo` 2: latched tempo code.
- `note_valid` 1: current note outputs are meaningful.
- `playing` 1: sequencer is not idle.
- `song_done` 1: single-cycle end-of-song pulse.

Function
REQ-006 SHALL decode records as follows: [11:6] pitch, [5:3] length, [2:0] ctrl. ctrl==3'b111 is END; any other ctrl value is an ordinary note.
REQ-007 SHALL treat the ROM as synchronous: `rom_data` reflects the `rom_addr` value registered one cycle earlier.
REQ-008 SHALL implement the FSM states IDLE, FETCH, LOAD, PLAY and DONE, with all outputs registered.
REQ-009 SHALL, in IDLE with `start`=1, set `rom_addr`=0, latch `tempo_sel` into `tempo`, and go to FETCH.
REQ-010 SHALL go from FETCH to LOAD unconditionally (ROM latency cycle).
REQ-011 SHALL, in LOAD with a non-END record, register pitch and length, set `note_valid`=1, and go to PLAY; the outputs update exactly 2 cycles after `start` is sampled.
REQ-012 SHALL, in PLAY with `play_next`=1, increment `rom_addr` modulo 2^ADDR_W (63 wraps to 0) and go to FETCH; `note_valid` and the note outputs SHALL hold until the next LOAD.
REQ-013 SHALL, in LOAD with an END record and `loop_en`=1, set `rom_addr`=0 and go to FETCH; `note_valid` SHALL drop to 0 until the next valid note.
REQ-014 SHALL, in LOAD with an END record and `loop_en`=0, go to DONE with `note_valid`=0.
REQ-015 SHALL, in DONE, assert `song_done` for exactly one cycle, then go to IDLE.
REQ-016 SHALL ignore `play_next` in every state except PLAY; a pulse arriving in FETCH or LOAD is dropped, not queued.
REQ-017 SHALL ignore `start` in every state except IDLE.
REQ-018 SHALL, when `stop`=1 in any state, go to IDLE on the next edge with `note_valid`=0, `rom_addr`=0 and `song_done`=0.
REQ-019 SHALL give `stop` priority over `start` and `play_next` when they are asserted in the same cycle.
REQ-020 SHALL drive `playing`=1 exactly when the state is not IDLE.
REQ-021 SHALL not fetch again while the tempo or length output is being consumed; exactly one ROM read occurs per note.
REQ-022 SHALL hold the latched `tempo` constant while playing; changes on `tempo_sel` SHALL take effect only at the next start.

Reset
REQ-023 SHALL, on `resetn`=0 at a rising edge, set: state=IDLE, `rom_addr`=0, `note_pitch`=0, `note_length`=0, `tempo`=0, `note_valid`=0, `playing`=0, `song_done`=0.
REQ-024 SHALL give reset priority over all other inputs, including mid-note or mid-fetch; no `song_done` is emitted on reset.

Structure
REQ-025 SHALL place the following in the shared package `synth_pkg`: the state encoding, the record field bit positions, the END ctrl code, and the ADDR_W and REC_W defaults.
REQ-026 SHALL keep the ROM outside this block, as sub-module `song_rom` (synchronous read, REC_W x 2^ADDR_W), instantiated beside the sequencer at top level; the sequencer SHALL contain no memory.

Verification
REQ-027 SHALL cover the basic note: ROM[0]={pitch 12, len 3, ctrl 0}, `start` at cycle 0 -> `note_pitch`=12, `note_length`=3, `note_valid`=1 at cycle 2, and `rom_addr` stays 0 until `play_next`.
REQ-028 SHALL cover end without loop: ROM[0..1] are notes, ROM[2]=END, `loop_en`=0, `play_next` pulsed twice -> `song_done` high for 1 cycle, `note_valid`=0, then `playing`=0.
REQ-029 SHALL cover loop: same ROM with `loop_en`=1 -> after END, `rom_addr` returns to 0 and ROM[0] is replayed; `song_done` never asserts.
REQ-030 SHALL cover the stop race: `stop` and `play_next` both high in PLAY -> IDLE next cycle, `rom_addr`=0, `note_valid`=0, and no fetch occurs.
REQ-031 SHALL cover wrap and dropped pulses: 64 non-END records with `play_next` in PLAY -> `rom_addr` goes 63 -> 0; a `play_next` injected in FETCH leaves `rom_addr` unchanged.
REQ-032 SHALL cover mid-fetch reset: `resetn` low in LOAD -> all outputs at their reset values on the next edge, and `song_done`=0 throughout.
